// File: rtl/clk_pll_pkg.sv
// ---------------------------------------------------------------------------
// clk_pll_pkg
// Shared definitions for the ECP5 PLL wrapper with dynamic phase stepping:
//   - ps_state_t   : phase-step controller states
//   - POS_W        : width of each accumulated phase-position counter
//   - N_PLL_OUT    : number of physical EHXPLLL outputs (OP, OS, OS2, OS3)
//   - phasesel_enc : maps a logical output index to the EHXPLLL PHASESEL code
// ---------------------------------------------------------------------------
package clk_pll_pkg;

    localparam int POS_W     = 10;
    localparam int N_PLL_OUT = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STEP_LO = 3'd2,
        ST_STEP_HI = 3'd3,
        ST_DONE    = 3'd4
    } ps_state_t;

    // The PLL's PHASESEL code is rotated relative to the output order:
    // OP=11, OS=00, OS2=01, OS3=10.
    function automatic logic [1:0] phasesel_enc(input logic [1:0] sel);
        logic [1:0] enc;
        case (sel)
            2'd0:    enc = 2'b11;
            2'd1:    enc = 2'b00;
            2'd2:    enc = 2'b01;
            default: enc = 2'b10;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/clk_lock_filter.sv
// ---------------------------------------------------------------------------
// clk_lock_filter
// Synchronises a raw PLL LOCK into the i_clk domain and only reports lock
// after it has been stable for LOCK_CNT consecutive synchronised cycles.
// Any synchronised low drops o_locked on the following cycle.
// Ports:
//   i_clk    : reference clock for the filter
//   i_rstn   : asynchronous active-low reset
//   i_lock   : raw, asynchronous PLL lock
//   o_locked : filtered lock (registered, i_clk domain)
// ---------------------------------------------------------------------------
module clk_lock_filter #(
    parameter int LOCK_CNT = 1024
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_lock,
    output logic o_locked
);

    localparam int CNT_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_locked;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else begin
            r_sync1 <= i_lock;
            r_sync2 <= r_sync1;
            // Counter saturates at CNT_MAX so it never wraps back to zero.
            if (!r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_locked <= r_sync2 && (r_cnt == CNT_MAX);
        end
    end

    assign o_locked = r_locked;

endmodule

// File: rtl/clk_pll_ehxplll_model.sv
// ---------------------------------------------------------------------------
// EHXPLLL (behavioural stand-in)
// Minimal port-compatible model of the Lattice ECP5 EHXPLLL primitive so the
// wrapper can be linted and simulated without the vendor library. All outputs
// follow CLKI and LOCK is high whenever the PLL is not held in reset/standby.
// Keep this file out of the synthesis file list: the vendor cell library
// provides the real primitive.
// Ports: identical names to the vendor primitive (CLKI, CLKFB, PHASE*,
//   ENCLK*, CLKO*, LOCK, INTLOCK, REFCLK, CLKINTFB, ...).
// ---------------------------------------------------------------------------
module EHXPLLL #(
    parameter int    CLKI_DIV      = 1,
    parameter int    CLKFB_DIV     = 1,
    parameter int    CLKOP_DIV     = 8,
    parameter int    CLKOS_DIV     = 8,
    parameter int    CLKOS2_DIV    = 8,
    parameter int    CLKOS3_DIV    = 8,
    parameter int    CLKOP_CPHASE  = 0,
    parameter int    CLKOS_CPHASE  = 0,
    parameter int    CLKOS2_CPHASE = 0,
    parameter int    CLKOS3_CPHASE = 0,
    parameter int    CLKOP_FPHASE  = 0,
    parameter int    CLKOS_FPHASE  = 0,
    parameter int    CLKOS2_FPHASE = 0,
    parameter int    CLKOS3_FPHASE = 0,
    parameter string CLKOP_ENABLE  = "ENABLED",
    parameter string CLKOS_ENABLE  = "DISABLED",
    parameter string CLKOS2_ENABLE = "DISABLED",
    parameter string CLKOS3_ENABLE = "DISABLED",
    parameter string FEEDBK_PATH   = "CLKOP",
    parameter string DPHASE_SOURCE = "DISABLED",
    parameter string PLLRST_ENA    = "DISABLED",
    parameter string STDBY_ENABLE  = "DISABLED",
    parameter string INTFB_WAKE    = "DISABLED"
) (
    input  logic CLKI,
    input  logic CLKFB,
    input  logic PHASESEL1,
    input  logic PHASESEL0,
    input  logic PHASEDIR,
    input  logic PHASESTEP,
    input  logic PHASELOADREG,
    input  logic STDBY,
    input  logic PLLWAKESYNC,
    input  logic RST,
    input  logic ENCLKOP,
    input  logic ENCLKOS,
    input  logic ENCLKOS2,
    input  logic ENCLKOS3,
    output logic CLKOP,
    output logic CLKOS,
    output logic CLKOS2,
    output logic CLKOS3,
    output logic LOCK,
    output logic INTLOCK,
    output logic REFCLK,
    output logic CLKINTFB
);

    localparam int NUM_SUM = CLKI_DIV + CLKFB_DIV + CLKOP_DIV + CLKOS_DIV
                           + CLKOS2_DIV + CLKOS3_DIV + CLKOP_CPHASE + CLKOS_CPHASE
                           + CLKOS2_CPHASE + CLKOS3_CPHASE + CLKOP_FPHASE
                           + CLKOS_FPHASE + CLKOS2_FPHASE + CLKOS3_FPHASE;
    localparam bit STR_ANY = (CLKOP_ENABLE != "") || (CLKOS_ENABLE != "")
                           || (CLKOS2_ENABLE != "") || (CLKOS3_ENABLE != "")
                           || (FEEDBK_PATH != "") || (DPHASE_SOURCE != "")
                           || (PLLRST_ENA != "") || (STDBY_ENABLE != "")
                           || (INTFB_WAKE != "");

    logic w_unused_cfg;
    assign w_unused_cfg = ^{CLKFB, PHASESEL1, PHASESEL0, PHASEDIR, PHASESTEP,
                            PHASELOADREG, PLLWAKESYNC, ENCLKOP, ENCLKOS,
                            ENCLKOS2, ENCLKOS3, (NUM_SUM != 0), STR_ANY};

    assign CLKOP    = CLKI;
    assign CLKOS    = CLKI;
    assign CLKOS2   = CLKI;
    assign CLKOS3   = CLKI;
    assign LOCK     = ~(RST | STDBY);
    assign INTLOCK  = LOCK;
    assign REFCLK   = CLKI;
    assign CLKINTFB = CLKI;

endmodule

// File: rtl/clk_pll_dynphase.sv
// ---------------------------------------------------------------------------
// clk_pll_dynphase
// ECP5 EHXPLLL wrapper with up to four outputs, a filtered lock output and a
// runtime phase-step controller driving the PLL dynamic-phase pins. Each
// accepted request selects an output, a direction and a step count; the
// controller sets up PHASESEL/PHASEDIR, emits the PHASESTEP low pulses and
// tracks the accumulated phase position per output (mod 8*DIV).
// Ports:
//   i_clkin    : 25 MHz reference, also clocks the controller
//   i_rstn     : asynchronous active-low reset
//   o_clkout   : PLL outputs, bit k = OP, OS, OS2, OS3
//   o_locked   : filtered lock in the i_clkin domain
//   i_ps_valid / o_ps_ready : request handshake
//   i_ps_sel   : output index, i_ps_dir: 0 delay / 1 advance
//   i_ps_count : number of steps (0 completes immediately)
//   o_ps_done  : one-cycle completion pulse, o_ps_err valid with it
//   o_ps_pos   : 4 x POS_W accumulated positions, output k at [k*POS_W +: POS_W]
// ---------------------------------------------------------------------------
module clk_pll_dynphase
    import clk_pll_pkg::*;
#(
    parameter int CLKI_DIV      = 1,
    parameter int CLKFB_DIV     = 4,
    parameter int CLKOP_DIV     = 6,
    parameter int CLKOS_DIV     = 6,
    parameter int CLKOS2_DIV    = 4,
    parameter int CLKOS3_DIV    = 6,
    parameter int CLKOP_CPHASE  = 0,
    parameter int CLKOS_CPHASE  = 0,
    parameter int CLKOS2_CPHASE = 0,
    parameter int CLKOS3_CPHASE = 0,
    parameter int CLKOP_FPHASE  = 0,
    parameter int CLKOS_FPHASE  = 0,
    parameter int CLKOS2_FPHASE = 0,
    parameter int CLKOS3_FPHASE = 0,
    parameter int N_OUT         = 3,
    parameter int STEP_LOW      = 4,
    parameter int STEP_GAP      = 4,
    parameter int SETUP_CYC     = 2,
    parameter int LOCK_CNT      = 1024
) (
    input  logic                   i_clkin,
    input  logic                   i_rstn,
    output logic [N_OUT-1:0]       o_clkout,
    output logic                   o_locked,
    input  logic                   i_ps_valid,
    output logic                   o_ps_ready,
    input  logic [1:0]             i_ps_sel,
    input  logic                   i_ps_dir,
    input  logic [7:0]             i_ps_count,
    output logic                   o_ps_done,
    output logic                   o_ps_err,
    output logic [4*POS_W-1:0]     o_ps_pos
);

    // Timer reload values; all phase timings are assumed to be 1..256 cycles.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] LOW_LD   = 8'(STEP_LOW - 1);
    localparam logic [7:0] GAP_LD   = 8'(STEP_GAP - 1);

    // ------------------------------------------------------------------
    // PLL primitive
    // ------------------------------------------------------------------
    logic [N_PLL_OUT-1:0] w_pll_clk;
    logic                 w_pll_lock;
    logic                 w_clkintfb;
    logic                 w_intlock;
    logic                 w_refclk;
    logic                 w_phasestep;
    logic [1:0]           r_phasesel;
    logic                 r_phasedir;

    (* ICP_CURRENT="12" *) (* LPF_RESISTOR="8" *)
    (* MFG_ENABLE_FILTEROPAMP="1" *) (* MFG_GMCREF_SEL="2" *)
    EHXPLLL #(
        .CLKI_DIV      (CLKI_DIV),
        .CLKFB_DIV     (CLKFB_DIV),
        .CLKOP_DIV     (CLKOP_DIV),
        .CLKOS_DIV     (CLKOS_DIV),
        .CLKOS2_DIV    (CLKOS2_DIV),
        .CLKOS3_DIV    (CLKOS3_DIV),
        .CLKOP_CPHASE  (CLKOP_CPHASE),
        .CLKOS_CPHASE  (CLKOS_CPHASE),
        .CLKOS2_CPHASE (CLKOS2_CPHASE),
        .CLKOS3_CPHASE (CLKOS3_CPHASE),
        .CLKOP_FPHASE  (CLKOP_FPHASE),
        .CLKOS_FPHASE  (CLKOS_FPHASE),
        .CLKOS2_FPHASE (CLKOS2_FPHASE),
        .CLKOS3_FPHASE (CLKOS3_FPHASE),
        .CLKOP_ENABLE  ("ENABLED"),
        .CLKOS_ENABLE  ((N_OUT >= 2) ? "ENABLED" : "DISABLED"),
        .CLKOS2_ENABLE ((N_OUT >= 3) ? "ENABLED" : "DISABLED"),
        .CLKOS3_ENABLE ((N_OUT >= 4) ? "ENABLED" : "DISABLED"),
        .FEEDBK_PATH   ("INT_OP"),
        .DPHASE_SOURCE ("ENABLED"),
        .PLLRST_ENA    ("DISABLED"),
        .STDBY_ENABLE  ("DISABLED"),
        .INTFB_WAKE    ("DISABLED")
    ) u_pll (
        .CLKI         (i_clkin),
        .CLKFB        (w_clkintfb),
        .PHASESEL1    (r_phasesel[1]),
        .PHASESEL0    (r_phasesel[0]),
        .PHASEDIR     (r_phasedir),
        .PHASESTEP    (w_phasestep),
        .PHASELOADREG (1'b0),
        .STDBY        (1'b0),
        .PLLWAKESYNC  (1'b0),
        .RST          (1'b0),
        .ENCLKOP      (1'b0),
        .ENCLKOS      (1'b0),
        .ENCLKOS2     (1'b0),
        .ENCLKOS3     (1'b0),
        .CLKOP        (w_pll_clk[0]),
        .CLKOS        (w_pll_clk[1]),
        .CLKOS2       (w_pll_clk[2]),
        .CLKOS3       (w_pll_clk[3]),
        .LOCK         (w_pll_lock),
        .INTLOCK      (w_intlock),
        .REFCLK       (w_refclk),
        .CLKINTFB     (w_clkintfb)
    );

    assign o_clkout = w_pll_clk[N_OUT-1:0];

    logic w_unused_pll;
    assign w_unused_pll = ^{w_pll_clk, w_intlock, w_refclk};

    // ------------------------------------------------------------------
    // Lock filter
    // ------------------------------------------------------------------
    logic w_locked;

    clk_lock_filter #(
        .LOCK_CNT (LOCK_CNT)
    ) u_lock_filter (
        .i_clk    (i_clkin),
        .i_rstn   (i_rstn),
        .i_lock   (w_pll_lock),
        .o_locked (w_locked)
    );

    assign o_locked = w_locked;

    // ------------------------------------------------------------------
    // Phase-step controller FSM
    // ------------------------------------------------------------------
    ps_state_t  r_state, w_state_next;
    logic [7:0] r_tmr, w_tmr_next;
    logic [7:0] r_rem, w_rem_next;
    logic [1:0] r_sel, w_sel_next;
    logic       r_dir, w_dir_next;
    logic       r_err, w_err_next;
    logic [1:0] w_phasesel_next;
    logic       w_phasedir_next;
    logic       w_step_evt;
    logic       w_ps_ready;
    logic       w_accept;

    assign w_ps_ready = w_locked && (r_state == ST_IDLE);
    assign w_accept   = i_ps_valid && w_ps_ready;

    always_ff @(posedge i_clkin or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= ST_IDLE;
            r_tmr      <= '0;
            r_rem      <= '0;
            r_sel      <= '0;
            r_dir      <= 1'b0;
            r_err      <= 1'b0;
            r_phasesel <= 2'b00;
            r_phasedir <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tmr      <= w_tmr_next;
            r_rem      <= w_rem_next;
            r_sel      <= w_sel_next;
            r_dir      <= w_dir_next;
            r_err      <= w_err_next;
            r_phasesel <= w_phasesel_next;
            r_phasedir <= w_phasedir_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_tmr_next      = r_tmr;
        w_rem_next      = r_rem;
        w_sel_next      = r_sel;
        w_dir_next      = r_dir;
        w_err_next      = r_err;
        w_phasesel_next = r_phasesel;
        w_phasedir_next = r_phasedir;
        w_step_evt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_sel_next = i_ps_sel;
                    w_dir_next = i_ps_dir;
                    w_err_next = 1'b0;
                    if (i_ps_count == 8'd0) begin
                        // Zero-step request completes without touching the pins.
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next    = ST_SETUP;
                        w_rem_next      = i_ps_count;
                        w_tmr_next      = SETUP_LD;
                        w_phasesel_next = phasesel_enc(i_ps_sel);
                        w_phasedir_next = i_ps_dir;
                    end
                end
            end
            ST_SETUP: begin
                if (!w_locked) begin
                    w_state_next = ST_DONE;
                    w_err_next   = 1'b1;
                end else if (r_tmr == 8'd0) begin
                    w_state_next = ST_STEP_LO;
                    w_tmr_next   = LOW_LD;
                end else begin
                    w_tmr_next = r_tmr - 8'd1;
                end
            end
            ST_STEP_LO: begin
                if (!w_locked) begin
                    w_state_next = ST_DONE;
                    w_err_next   = 1'b1;
                end else if (r_tmr == 8'd0) begin
                    // A step counts as applied once PHASESTEP rises again.
                    w_state_next = ST_STEP_HI;
                    w_tmr_next   = GAP_LD;
                    w_rem_next   = r_rem - 8'd1;
                    w_step_evt   = 1'b1;
                end else begin
                    w_tmr_next = r_tmr - 8'd1;
                end
            end
            ST_STEP_HI: begin
                if (!w_locked) begin
                    w_state_next = ST_DONE;
                    w_err_next   = 1'b1;
                end else if (r_tmr == 8'd0) begin
                    if (r_rem == 8'd0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_STEP_LO;
                        w_tmr_next   = LOW_LD;
                    end
                end else begin
                    w_tmr_next = r_tmr - 8'd1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // PHASESTEP is gated by the filtered lock so it releases in the same
    // cycle lock is lost, not one cycle later when the FSM leaves STEP_LO.
    assign w_phasestep = !((r_state == ST_STEP_LO) && w_locked);

    assign o_ps_ready = w_ps_ready;
    assign o_ps_done  = (r_state == ST_DONE);
    assign o_ps_err   = (r_state == ST_DONE) && r_err;

    // ------------------------------------------------------------------
    // Accumulated phase position per output, modulo 8*DIV
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_PLL_OUT; gi++) begin : g_pos
            localparam int DIV = (gi == 0) ? CLKOP_DIV :
                                 (gi == 1) ? CLKOS_DIV :
                                 (gi == 2) ? CLKOS2_DIV : CLKOS3_DIV;
            localparam logic [POS_W-1:0] POS_MAX = POS_W'(8 * DIV - 1);

            if (gi < N_OUT) begin : g_on
                logic [POS_W-1:0] r_pos;

                always_ff @(posedge i_clkin or negedge i_rstn) begin
                    if (!i_rstn) begin
                        r_pos <= '0;
                    end else if (w_step_evt && (r_sel == 2'(gi))) begin
                        if (!r_dir) begin
                            r_pos <= (r_pos == POS_MAX) ? '0 : r_pos + 1'b1;
                        end else begin
                            r_pos <= (r_pos == '0) ? POS_MAX : r_pos - 1'b1;
                        end
                    end
                end

                assign o_ps_pos[gi*POS_W +: POS_W] = r_pos;
            end else begin : g_off
                // Steps on a disabled output still pulse the pins but are
                // not tracked.
                assign o_ps_pos[gi*POS_W +: POS_W] = '0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_clk_pll_dynphase.sv
// ---------------------------------------------------------------------------
// tb_clk_pll_dynphase
// Directed testbench for clk_pll_dynphase: lock filtering, step timing,
// position wrap, zero-count and disabled-output requests, lock loss and
// asynchronous reset during a request.
// ---------------------------------------------------------------------------
module tb_clk_pll_dynphase;

    localparam int LOCK_CNT = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  clkout;
    logic        locked;
    logic        ps_valid;
    logic        ps_ready;
    logic [1:0]  ps_sel;
    logic        ps_dir;
    logic [7:0]  ps_count;
    logic        ps_done;
    logic        ps_err;
    logic [39:0] ps_pos;

    logic        pstep;
    logic [1:0]  psel;
    logic        pdir;

    int n_tests = 0;
    int n_fail  = 0;

    clk_pll_dynphase #(
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .i_clkin    (clk),
        .i_rstn     (rstn),
        .o_clkout   (clkout),
        .o_locked   (locked),
        .i_ps_valid (ps_valid),
        .o_ps_ready (ps_ready),
        .i_ps_sel   (ps_sel),
        .i_ps_dir   (ps_dir),
        .i_ps_count (ps_count),
        .o_ps_done  (ps_done),
        .o_ps_err   (ps_err),
        .o_ps_pos   (ps_pos)
    );

    assign pstep = dut.w_phasestep;
    assign psel  = dut.r_phasesel;
    assign pdir  = dut.r_phasedir;

    always #20 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a request and wait for the accept edge; returns at sample #1.
    task automatic accept(input logic [1:0] sel, input logic dir, input logic [7:0] cnt,
                          output logic ok);
        int w;
        @(negedge clk);
        ps_sel   = sel;
        ps_dir   = dir;
        ps_count = cnt;
        ps_valid = 1'b1;
        w = 0;
        while (!ps_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (!ps_ready) begin
            n_fail++;
            $display("FAIL accept_ready: ready=%0b required=1 after %0d cycles", ps_ready, w);
            ps_valid = 1'b0;
            ok = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ps_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    // Run one request to completion, collecting pin and timing observations.
    task automatic run_req(input logic [1:0] sel, input logic dir, input logic [7:0] cnt,
                           input logic [1:0] exp_enc, output int done_at, output logic err,
                           output int n_low, output logic len_ok, output logic setup_ok);
        logic ok;
        int   run;
        done_at  = -1;
        err      = 1'b0;
        n_low    = 0;
        len_ok   = 1'b1;
        setup_ok = 1'b1;
        run      = 0;
        accept(sel, dir, cnt, ok);
        if (ok) begin
            for (int k = 1; k <= 3000; k++) begin
                if (cnt != 0 && k <= 2) begin
                    if (psel !== exp_enc || pdir !== dir || pstep !== 1'b1) setup_ok = 1'b0;
                end
                if (pstep === 1'b0) begin
                    run++;
                end else if (run > 0) begin
                    n_low++;
                    if (run != 4) len_ok = 1'b0;
                    run = 0;
                end
                if (ps_done === 1'b1) begin
                    done_at = k;
                    err     = ps_err;
                    break;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset;
        rstn     = 1'b0;
        ps_valid = 1'b0;
        ps_sel   = 2'd0;
        ps_dir   = 1'b0;
        ps_count = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %0b want 0", locked); end
        n_tests++; if (ps_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b want 0", ps_ready); end
        n_tests++; if (ps_done !== 1'b0 || ps_err !== 1'b0) begin n_fail++; $display("FAIL rst_done_err: got %0b/%0b want 0/0", ps_done, ps_err); end
        n_tests++; if (ps_pos !== 40'd0) begin n_fail++; $display("FAIL rst_pos: got %h want 0", ps_pos); end
        n_tests++; if (pstep !== 1'b1 || psel !== 2'b00 || pdir !== 1'b0) begin n_fail++; $display("FAIL rst_pins: step=%0b sel=%b dir=%0b want 1/00/0", pstep, psel, pdir); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL nolock_locked: got %0b want 0", locked); end
    endtask

    task automatic test_lock;
        force dut.w_pll_lock = 1'b1;
        for (int i = 1; i <= LOCK_CNT + 2; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (locked !== ((i == LOCK_CNT + 2) ? 1'b1 : 1'b0) || ps_ready !== locked) begin
                n_fail++;
                $display("FAIL lock_rise: cycle %0d locked=%0b ready=%0b want locked=%0b", i, locked, ps_ready, (i == LOCK_CNT + 2));
            end
        end
    endtask

    task automatic test_step_basic;
        int d; logic e; int nl; logic lo; logic so;
        run_req(2'd1, 1'b0, 8'd3, 2'b00, d, e, nl, lo, so);
        n_tests++; if (d != 27) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 27", d); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %0b want 0", e); end
        n_tests++; if (nl != 3 || lo !== 1'b1) begin n_fail++; $display("FAIL basic_pulses: got %0d len_ok=%0b want 3/1", nl, lo); end
        n_tests++; if (so !== 1'b1) begin n_fail++; $display("FAIL basic_setup: got %0b want 1", so); end
        n_tests++; if (ps_pos !== 40'd3072) begin n_fail++; $display("FAIL basic_pos: got %h want %h", ps_pos, 40'd3072); end
    endtask

    task automatic test_wrap;
        int d; logic e; int nl; logic lo; logic so;
        run_req(2'd1, 1'b1, 8'd3, 2'b00, d, e, nl, lo, so);
        n_tests++; if (ps_pos[19:10] !== 10'd0) begin n_fail++; $display("FAIL wrap_back0: got %0d want 0", ps_pos[19:10]); end
        run_req(2'd1, 1'b1, 8'd2, 2'b00, d, e, nl, lo, so);
        n_tests++; if (d != 19 || nl != 2) begin n_fail++; $display("FAIL wrap_adv_timing: done=%0d pulses=%0d want 19/2", d, nl); end
        n_tests++; if (ps_pos[19:10] !== 10'd46) begin n_fail++; $display("FAIL wrap_under: got %0d want 46", ps_pos[19:10]); end
        run_req(2'd1, 1'b0, 8'd3, 2'b00, d, e, nl, lo, so);
        n_tests++; if (ps_pos[19:10] !== 10'd1) begin n_fail++; $display("FAIL wrap_over: got %0d want 1", ps_pos[19:10]); end
        n_tests++; if (ps_pos !== 40'd1024) begin n_fail++; $display("FAIL wrap_others: got %h want %h", ps_pos, 40'd1024); end
    endtask

    task automatic test_count_zero;
        int d; logic e; int nl; logic lo; logic so;
        run_req(2'd0, 1'b1, 8'd0, 2'b11, d, e, nl, lo, so);
        n_tests++; if (d != 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 1", d); end
        n_tests++; if (nl != 0 || e !== 1'b0) begin n_fail++; $display("FAIL zero_pins: pulses=%0d err=%0b want 0/0", nl, e); end
        n_tests++; if (psel !== 2'b00 || ps_pos !== 40'd1024) begin n_fail++; $display("FAIL zero_state: sel=%b pos=%h want 00/%h", psel, ps_pos, 40'd1024); end
    endtask

    task automatic test_unused_output;
        int d; logic e; int nl; logic lo; logic so;
        run_req(2'd3, 1'b0, 8'd1, 2'b10, d, e, nl, lo, so);
        n_tests++; if (d != 11 || nl != 1 || so !== 1'b1) begin n_fail++; $display("FAIL os3_pins: done=%0d pulses=%0d setup=%0b want 11/1/1", d, nl, so); end
        n_tests++; if (ps_pos !== 40'd1024) begin n_fail++; $display("FAIL os3_pos: got %h want %h", ps_pos, 40'd1024); end
    endtask

    task automatic test_lock_loss(output logic [9:0] pos2);
        logic ok;
        int   k;
        int   first_low;
        int   done_k;
        logic err_seen;
        logic extra_done;
        accept(2'd2, 1'b0, 8'd5, ok);
        n_tests++; if (psel !== 2'b01) begin n_fail++; $display("FAIL loss_sel: got %b want 01", psel); end
        for (k = 1; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        force dut.w_pll_lock = 1'b0;
        first_low = -1;
        done_k    = -1;
        err_seen  = 1'b0;
        for (int j = 0; j < 40 && done_k < 0; j++) begin
            @(posedge clk);
            #1;
            k++;
            if (locked === 1'b0 && first_low < 0) begin
                first_low = k;
                n_tests++; if (pstep !== 1'b1) begin n_fail++; $display("FAIL loss_step_release: step=%0b want 1 at cycle %0d", pstep, k); end
            end
            if (ps_done === 1'b1) begin
                done_k   = k;
                err_seen = ps_err;
            end
        end
        n_tests++; if (first_low < 0 || done_k < 0) begin n_fail++; $display("FAIL loss_timeout: locked_low_at=%0d done_at=%0d want both seen", first_low, done_k); end
        n_tests++; if (err_seen !== 1'b1) begin n_fail++; $display("FAIL loss_err: got %0b want 1", err_seen); end
        n_tests++; if (ps_pos[29:20] !== 10'd1 && ps_pos[29:20] !== 10'd2) begin n_fail++; $display("FAIL loss_pos: got %0d want 1 or 2", ps_pos[29:20]); end
        pos2 = ps_pos[29:20];
        // Requests while unlocked must be dropped, not queued.
        @(negedge clk);
        ps_sel = 2'd1; ps_dir = 1'b0; ps_count = 8'd1; ps_valid = 1'b1;
        extra_done = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            if (ps_ready !== 1'b0 || ps_done !== 1'b0) extra_done = 1'b1;
        end
        @(negedge clk);
        ps_valid = 1'b0;
        n_tests++; if (extra_done !== 1'b0) begin n_fail++; $display("FAIL loss_no_accept: ready/done seen=%0b want 0", extra_done); end
        repeat (20) @(posedge clk);
        #1;
        n_tests++; if (ps_pos[19:10] !== 10'd1 || dut.r_state != 3'd0) begin n_fail++; $display("FAIL loss_not_queued: pos1=%0d state=%0d want 1/0", ps_pos[19:10], dut.r_state); end
        force dut.w_pll_lock = 1'b1;
        k = 0;
        while (locked !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock: got %0b want 1", locked); end
    endtask

    task automatic test_async_reset(input logic [9:0] pos2);
        logic       ok;
        logic [9:0] exp2;
        exp2 = (pos2 == 10'd31) ? 10'd0 : pos2 + 10'd1;
        accept(2'd2, 1'b0, 8'd3, ok);
        for (int k = 1; k < 12; k++) begin
            @(posedge clk);
            #1;
        end
        n_tests++; if (pstep !== 1'b0 || ps_pos[29:20] !== exp2) begin n_fail++; $display("FAIL arst_pre: step=%0b pos2=%0d want 0/%0d", pstep, ps_pos[29:20], exp2); end
        #5;
        rstn = 1'b0;
        #1;
        n_tests++; if (pstep !== 1'b1) begin n_fail++; $display("FAIL arst_step: got %0b want 1", pstep); end
        n_tests++; if (ps_pos !== 40'd0) begin n_fail++; $display("FAIL arst_pos: got %h want 0", ps_pos); end
        n_tests++; if (locked !== 1'b0 || ps_ready !== 1'b0 || ps_done !== 1'b0) begin n_fail++; $display("FAIL arst_flags: locked=%0b ready=%0b done=%0b want 0/0/0", locked, ps_ready, ps_done); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [9:0] pos2;
        force dut.w_pll_lock = 1'b0;
        test_reset();
        test_lock();
        test_step_basic();
        test_wrap();
        test_count_zero();
        test_unused_output();
        test_lock_loss(pos2);
        test_async_reset(pos2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_pll_dynphase.md
Name: clk_pll_dynphase

Overview:
Parametrised ECP5 EHXPLLL wrapper for ULX3S: up to four outputs with divider and static phase set by parameters. Adds a runtime phase-step controller for the PLL dynamic phase pins and a filtered, synchronised lock output. Sits at the top of the clock tree. The SDRAM/video logic uses it to tune its sample-clock phase at run time instead of needing a new bitstream.

Parameters:
CLKI_DIV, 1, PLL input divider
CLKFB_DIV, 4, feedback divider (FEEDBK_PATH "INT_OP")
CLKOP_DIV / CLKOS_DIV / CLKOS2_DIV / CLKOS3_DIV, 6/6/4/6, output dividers (1..128)
CLKOx_CPHASE / CLKOx_FPHASE, 0, static coarse/fine phase per output
N_OUT, 3, number of enabled outputs (1..4); clkout[k] maps to OP, OS, OS2, OS3
STEP_LOW, 4, clkin cycles PHASESTEP held low per step
STEP_GAP, 4, clkin cycles PHASESTEP held high between steps
SETUP_CYC, 2, clkin cycles that PHASESEL/PHASEDIR are stable before the first step
LOCK_CNT, 1024, consecutive synchronised-lock cycles needed before locked asserts

Ports:
clkin  in  1  25 MHz reference; also clocks all controller logic
rstn  in  1  asynchronous active-low reset
clkout  out  N_OUT  PLL outputs
locked  out  1  filtered lock, clkin domain
ps_valid  in  1  phase-step request
ps_ready  out  1  controller can accept a request
ps_sel  in  2  target output index (0=OP,1=OS,2=OS2,3=OS3)
ps_dir  in  1  0 = delay (+phase), 1 = advance (-phase)
ps_count  in  8  number of steps
ps_done  out  1  one-cycle pulse when a request completes
ps_err  out  1  valid with ps_done; request aborted
ps_pos  out  4x10  accumulated step position per output, 10 bits each

Behaviour:
- Reset values: locked=0, ps_ready=0, ps_done=0, ps_err=0, ps_pos all 0, PHASESTEP=1, PHASELOADREG=0, PHASESEL=00, PHASEDIR=0, FSM=IDLE.
- Lock filter: PLL LOCK passes through a 2-flop synchroniser. A counter increments while the synchronised lock is 1 and clears while it is 0. locked=1 once the count reaches LOCK_CNT-1 (saturating). Any synchronised 0 drops locked on the next cycle.
- Handshake: the request transfers when ps_valid & ps_ready. ps_ready = locked & state==IDLE. The controller latches sel, dir and count at the transfer.
- Pin mapping: ps_sel 0→PHASESEL 11, 1→00, 2→01, 3→10. PHASEDIR = ps_dir.
- FSM:
  - IDLE: on accept, go to SETUP if count≠0. If count=0, pulse ps_done next cycle with no pin activity.
  - SETUP: drive sel/dir for SETUP_CYC cycles, then STEP_LO.
  - STEP_LO: PHASESTEP=0 for STEP_LOW cycles, then STEP_HI.
  - STEP_HI: PHASESTEP=1 for STEP_GAP cycles. Decrement the remaining count and update ps_pos on STEP_HI entry. If remaining=0 go to DONE, else STEP_LO.
  - DONE: ps_done=1 for one cycle, then IDLE.
- Duration: count=N takes SETUP_CYC + N*(STEP_LOW+STEP_GAP) + 1 cycles from accept to ps_done.
- ps_pos[k]: +1 per delay step, -1 per advance step, modulo 8*CLKOx_DIV of that output.
  - 0 minus 1 wraps to 8*DIV-1.
  - 8*DIV-1 plus 1 wraps to 0.
  - Output indices ≥ N_OUT are accepted and pulse pins, but their ps_pos stays 0.
- Lock loss mid-request (locked falls in SETUP/STEP_LO/STEP_HI):
  - PHASESTEP returns high immediately.
  - Go to DONE and pulse ps_done with ps_err=1.
  - Steps already completed stay in ps_pos.
- ps_valid while not ready is ignored; it is not queued.
- Async reset mid-request: everything returns to reset values at once. ps_pos resets; the phase already applied inside the PLL is not reset until the PLL relocks.
- PLL tie-offs: RST=0, STDBY=0, PLLWAKESYNC=0, ENCLKOP=0. Analog attributes are fixed: ICP_CURRENT 12, LPF_RESISTOR 8.

Decomposition:
- Shared package clk_pll_pkg: FSM state enum, ps_sel→PHASESEL encoding function, POS_W=10 constant.
- Sub-module clk_lock_filter: synchroniser plus saturating counter, parameter LOCK_CNT, reusable by other clock wrappers.
- FSM and EHXPLLL instance stay in the top.

Test Plan:
- Reset then PLL model LOCK=1 → locked rises exactly LOCK_CNT+2 cycles after LOCK (LOCK_CNT=16 in bench). ps_ready follows in the same cycle.
- Request sel=1, dir=0, count=3 (SETUP_CYC=2, STEP_LOW=4, STEP_GAP=4):
  - PHASESEL=00 and PHASEDIR=0 are stable for 2 cycles.
  - Exactly 3 low pulses of 4 cycles each.
  - ps_done at cycle 27 after accept.
  - ps_pos[1]=3, ps_err=0.
- Wrap: CLKOS_DIV=6, from ps_pos[1]=0, request dir=1, count=2 → ps_pos[1]=46. Then dir=0, count=3 → ps_pos[1]=1.
- count=0 request → ps_done one cycle after accept, PHASESTEP never low, ps_pos unchanged.
- Drop LOCK during the second step of count=5 → locked falls, PHASESTEP high within 1 cycle of locked falling, ps_done with ps_err=1, ps_pos advanced by 1 or 2 steps. ps_valid during the loss is not accepted.
- Assert rstn=0 during STEP_LO → same-cycle async return: PHASESTEP=1, ps_pos=0, locked=0, ps_ready=0.
